// File: rtl/gray_pkg.sv
// Shared constants for the shared Gray-to-binary converter: default sizing
// and the output-stage state encoding.
package gray_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;
  localparam int IDW_DEF   = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational Gray-to-binary conversion: each binary bit is the XOR
// of its Gray bit with every more-significant Gray bit.
module gray2bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // running XOR from the MSB down
  always_comb begin
    logic acc_s;
    acc_s          = gray[WIDTH-1];
    bin            = '0;
    bin[WIDTH-1]   = acc_s;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      acc_s  = acc_s ^ gray[i];
      bin[i] = acc_s;
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter among NREQ
// requesters, with a single-entry registered output stage.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = IDW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_gray,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_bin,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDW-1:0]   rr_ptr_r;
  logic [IDW-1:0]   ptr_nxt_s;
  logic [IDW-1:0]   win_s;
  logic             found_s;
  logic             can_accept_s;
  logic             take_s;
  logic [WIDTH-1:0] win_gray_s;
  logic [WIDTH-1:0] win_bin_s;
  logic [WIDTH-1:0] out_bin_r;
  logic [IDW-1:0]   out_id_r;

  // winner = valid requester at the smallest wrapped distance above rr_ptr
  always_comb begin
    int  dist_s;
    int  best_s;
    logic hit_s;
    win_s   = '0;
    found_s = 1'b0;
    best_s  = NREQ;
    dist_s  = 0;
    hit_s   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      dist_s  = (i >= int'(rr_ptr_r)) ? (i - int'(rr_ptr_r)) : (i - int'(rr_ptr_r) + NREQ);
      hit_s   = req_valid[i] && (dist_s < best_s);
      best_s  = hit_s ? dist_s : best_s;
      win_s   = hit_s ? IDW'(i) : win_s;
      found_s = found_s | hit_s;
    end
  end

  // select the winning Gray word for the shared converter
  always_comb begin
    win_gray_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_gray_s = win_gray_s | ({WIDTH{win_s == IDW'(i)}} & req_gray[i*WIDTH +: WIDTH]);
    end
  end

  assign can_accept_s = (state_r == EMPTY) | out_ready;
  assign take_s       = can_accept_s & found_s;
  assign ptr_nxt_s    = (win_s == IDW'(NREQ - 1)) ? '0 : (win_s + IDW'(1));

  // one-hot grant, forced low while reset is asserted
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = take_s & rst_n & (win_s == IDW'(i));
    end
  end

  gray2bin_comb #(
    .WIDTH(WIDTH)
  ) u_gray2bin (
    .gray(win_gray_s),
    .bin (win_bin_s)
  );

  // output-stage occupancy: a grant always refills, otherwise drain on out_ready
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        state_nxt_s = take_s ? FULL : EMPTY;
      end
      FULL: begin
        if (out_ready) begin
          state_nxt_s = take_s ? FULL : EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // state, pointer and result registers; data and pointer move only on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= EMPTY;
      rr_ptr_r  <= '0;
      out_bin_r <= '0;
      out_id_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (take_s) begin
        out_bin_r <= win_bin_s;
        out_id_r  <= win_s;
        rr_ptr_r  <= ptr_nxt_s;
      end else begin
        out_bin_r <= out_bin_r;
        out_id_r  <= out_id_r;
        rr_ptr_r  <= rr_ptr_r;
      end
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_bin   = out_bin_r;
  assign out_id    = out_id_r;
  assign busy      = out_valid | (|req_valid);

endmodule
